mem_bus_ctrl: RTL and testbench

//  Data-side memory bus master between the MEM stage and physical targets. Consumes the

---
 rtl/mem_bus_ctrl_pkg.sv | 35 +++
 rtl/mem_bus_ctrl_sram_port.sv | 96 +++++++++
 rtl/mem_bus_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the data-side memory bus master: target codes, FSM states,
// UART register offsets and the LSR status byte layout.
package mem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      USE_BASE = 2'd0,
      USE_EXT  = 2'd1,
      USE_UART = 2'd2,
      USE_VGA  = 2'd3
   } mem_use_t;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      SRAM_RD      = 3'd1,
      SRAM_WR      = 3'd2,
      SRAM_WR_END  = 3'd3,
      UART_TX_WAIT = 3'd4,
      DONE         = 3'd5
   } bus_state_t;

   localparam logic [2:0] UART_DATA_OFS = 3'd0;
   localparam logic [2:0] UART_LSR_OFS  = 3'd5;

   localparam int LSR_RX_READY_BIT = 0;
   localparam int LSR_TX_EMPTY_BIT = 5;

   function automatic logic [7:0] uart_lsr(input logic rx_ready, input logic tx_busy);
      logic [7:0] lsr;
      lsr = 8'h00;
      lsr[LSR_RX_READY_BIT] = rx_ready;
      lsr[LSR_TX_EMPTY_BIT] = ~tx_busy;
      return lsr;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_sram_port.sv
// One asynchronous SRAM port: drives ce/oe/we/be/data for a single access and
// times the strobe with a down-counter that completes at terminal count zero.
module mem_bus_ctrl_sram_port #(
   parameter int SRAM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [19:0] addr,
   input  logic [31:0] wdata,
   output logic        tc,
   output logic        done,
   output logic [31:0] rdata,
   output logic [19:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic [31:0] ram_data_o,
   output logic        ram_data_oe,
   input  logic [31:0] ram_data_i
);

   localparam int WAIT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SRAM_WAIT - 1);

   typedef enum logic [1:0] {P_IDLE, P_ACCESS, P_HOLD} phase_t;

   phase_t            phase;
   logic [WAIT_W-1:0] cnt;
   logic              we_q;

   assign tc    = (phase == P_ACCESS) && (cnt == '0);
   assign done  = (tc && !we_q) || (phase == P_HOLD);
   assign rdata = ram_data_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= P_IDLE;
         cnt         <= '0;
         we_q        <= 1'b0;
         ram_addr    <= '0;
         ram_be_n    <= 4'hF;
         ram_ce_n    <= 1'b1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
         ram_data_o  <= '0;
         ram_data_oe <= 1'b0;
      end else begin
         case (phase)
            P_IDLE: begin
               if (start) begin
                  phase    <= P_ACCESS;
                  cnt      <= WAIT_LOAD;
                  we_q     <= we;
                  ram_addr <= addr;
                  ram_ce_n <= 1'b0;
                  if (we) begin
                     ram_we_n    <= 1'b0;
                     ram_data_oe <= 1'b1;
                     ram_data_o  <= wdata;
                     ram_be_n    <= ~be;
                  end else begin
                     ram_oe_n <= 1'b0;
                     ram_be_n <= 4'h0;
                  end
               end
            end
            P_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (we_q) begin
                  // we rises first; ce and data stay driven one more cycle for hold time
                  ram_we_n <= 1'b1;
                  phase    <= P_HOLD;
               end else begin
                  ram_ce_n <= 1'b1;
                  ram_oe_n <= 1'b1;
                  ram_be_n <= 4'hF;
                  phase    <= P_IDLE;
               end
            end
            P_HOLD: begin
               ram_ce_n    <= 1'b1;
               ram_data_oe <= 1'b0;
               ram_be_n    <= 4'hF;
               phase       <= P_IDLE;
            end
            default: phase <= P_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-side memory bus master: runs one access per request to base/ext SRAM,
// the UART registers or the VGA framebuffer, then pulses mem_ready.
//
// state        | meaning
// IDLE         | waiting for mem_req; latches target and dispatches
// SRAM_RD      | selected SRAM ce/oe low until its wait counter expires
// SRAM_WR      | selected SRAM we low until its wait counter expires
// SRAM_WR_END  | we released, ce/data held one cycle
// UART_TX_WAIT | waiting for transmitter idle before tx_start
// DONE         | mem_ready high for one cycle
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int SRAM_WAIT = 2,
   parameter int VGA_AW    = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_be,
   input  logic [1:0]        mem_use,
   input  logic [19:0]       ram_addr,
   output logic [31:0]       mem_rdata,
   output logic              mem_ready,
   output logic [19:0]       base_ram_addr,
   output logic [3:0]        base_ram_be_n,
   output logic              base_ram_ce_n,
   output logic              base_ram_oe_n,
   output logic              base_ram_we_n,
   output logic [31:0]       base_ram_data_o,
   output logic              base_ram_data_oe,
   input  logic [31:0]       base_ram_data_i,
   output logic [19:0]       ext_ram_addr,
   output logic [3:0]        ext_ram_be_n,
   output logic              ext_ram_ce_n,
   output logic              ext_ram_oe_n,
   output logic              ext_ram_we_n,
   output logic [31:0]       ext_ram_data_o,
   output logic              ext_ram_data_oe,
   input  logic [31:0]       ext_ram_data_i,
   input  logic              uart_rx_ready,
   input  logic [7:0]        uart_rx_data,
   output logic              uart_rx_clear,
   input  logic              uart_tx_busy,
   output logic              uart_tx_start,
   output logic [7:0]        uart_tx_data,
   output logic              vga_we,
   output logic [VGA_AW-1:0] vga_addr,
   output logic [7:0]        vga_wdata
);

   bus_state_t  state;
   mem_use_t    use_q;
   logic [7:0]  tx_byte_q;
   logic        accept;
   logic        base_start, ext_start;
   logic        base_tc, base_done, ext_tc, ext_done;
   logic [31:0] base_rdata, ext_rdata;
   logic        port_tc, port_done;
   logic [31:0] port_rdata;
   logic        unused_addr_bits;

   assign accept     = (state == IDLE) && mem_req;
   assign base_start = accept && (mem_use_t'(mem_use) == USE_BASE);
   assign ext_start  = accept && (mem_use_t'(mem_use) == USE_EXT);

   assign port_tc    = (use_q == USE_EXT) ? ext_tc    : base_tc;
   assign port_done  = (use_q == USE_EXT) ? ext_done  : base_done;
   assign port_rdata = (use_q == USE_EXT) ? ext_rdata : base_rdata;

   assign unused_addr_bits = ^mem_addr[31:VGA_AW];

   mem_bus_ctrl_sram_port #(.SRAM_WAIT(SRAM_WAIT)) u_base_port (
      .clk(clk), .rst_n(rst_n), .start(base_start), .we(mem_we), .be(mem_be),
      .addr(ram_addr), .wdata(mem_wdata), .tc(base_tc), .done(base_done), .rdata(base_rdata),
      .ram_addr(base_ram_addr), .ram_be_n(base_ram_be_n), .ram_ce_n(base_ram_ce_n),
      .ram_oe_n(base_ram_oe_n), .ram_we_n(base_ram_we_n), .ram_data_o(base_ram_data_o),
      .ram_data_oe(base_ram_data_oe), .ram_data_i(base_ram_data_i)
   );

   mem_bus_ctrl_sram_port #(.SRAM_WAIT(SRAM_WAIT)) u_ext_port (
      .clk(clk), .rst_n(rst_n), .start(ext_start), .we(mem_we), .be(mem_be),
      .addr(ram_addr), .wdata(mem_wdata), .tc(ext_tc), .done(ext_done), .rdata(ext_rdata),
      .ram_addr(ext_ram_addr), .ram_be_n(ext_ram_be_n), .ram_ce_n(ext_ram_ce_n),
      .ram_oe_n(ext_ram_oe_n), .ram_we_n(ext_ram_we_n), .ram_data_o(ext_ram_data_o),
      .ram_data_oe(ext_ram_data_oe), .ram_data_i(ext_ram_data_i)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         use_q         <= USE_BASE;
         tx_byte_q     <= '0;
         mem_ready     <= 1'b0;
         mem_rdata     <= '0;
         uart_rx_clear <= 1'b0;
         uart_tx_start <= 1'b0;
         uart_tx_data  <= '0;
         vga_we        <= 1'b0;
         vga_addr      <= '0;
         vga_wdata     <= '0;
      end else begin
         mem_ready     <= 1'b0;
         uart_rx_clear <= 1'b0;
         uart_tx_start <= 1'b0;
         vga_we        <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req) begin
                  use_q     <= mem_use_t'(mem_use);
                  tx_byte_q <= mem_wdata[7:0];
                  case (mem_use_t'(mem_use))
                     USE_BASE, USE_EXT: state <= mem_we ? SRAM_WR : SRAM_RD;
                     USE_UART: begin
                        if (mem_we) begin
                           if (mem_addr[2:0] == UART_DATA_OFS) begin
                              state <= UART_TX_WAIT;
                           end else begin
                              state     <= DONE;
                              mem_ready <= 1'b1;
                           end
                        end else begin
                           state     <= DONE;
                           mem_ready <= 1'b1;
                           case (mem_addr[2:0])
                              UART_DATA_OFS: begin
                                 mem_rdata     <= {24'b0, uart_rx_data};
                                 uart_rx_clear <= 1'b1;
                              end
                              UART_LSR_OFS: mem_rdata <= {16'b0, uart_lsr(uart_rx_ready, uart_tx_busy), 8'b0};
                              default:      mem_rdata <= '0;
                           endcase
                        end
                     end
                     default: begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                        if (mem_we) begin
                           vga_we    <= 1'b1;
                           vga_addr  <= mem_addr[VGA_AW-1:0];
                           vga_wdata <= mem_wdata[7:0];
                        end else begin
                           mem_rdata <= '0;
                        end
                     end
                  endcase
               end
            end
            SRAM_RD: begin
               if (port_done) begin
                  mem_rdata <= port_rdata;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            SRAM_WR: begin
               if (port_tc) state <= SRAM_WR_END;
            end
            SRAM_WR_END: begin
               if (port_done) begin
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            UART_TX_WAIT: begin
               if (!uart_tx_busy) begin
                  uart_tx_start <= 1'b1;
                  uart_tx_data  <= tx_byte_q;
                  mem_ready     <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: SRAM read/write timing, UART data/LSR/tx handshake,
// VGA writes and asynchronous reset during an SRAM write.
module tb_mem_bus_ctrl;
   import mem_bus_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [1:0]  mem_use;
   logic [19:0] ram_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [19:0] base_ram_addr, ext_ram_addr;
   logic [3:0]  base_ram_be_n, ext_ram_be_n;
   logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_data_oe;
   logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_data_oe;
   logic [31:0] base_ram_data_o, base_ram_data_i, ext_ram_data_o, ext_ram_data_i;
   logic        uart_rx_ready, uart_rx_clear, uart_tx_busy, uart_tx_start;
   logic [7:0]  uart_rx_data, uart_tx_data;
   logic        vga_we;
   logic [18:0] vga_addr;
   logic [7:0]  vga_wdata;

   int total = 0;
   int bad   = 0;

   mem_bus_ctrl #(.SRAM_WAIT(2), .VGA_AW(19)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_use(mem_use), .ram_addr(ram_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
      .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n), .base_ram_data_o(base_ram_data_o),
      .base_ram_data_oe(base_ram_data_oe), .base_ram_data_i(base_ram_data_i),
      .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
      .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n), .ext_ram_data_o(ext_ram_data_o),
      .ext_ram_data_oe(ext_ram_data_oe), .ext_ram_data_i(ext_ram_data_i),
      .uart_rx_ready(uart_rx_ready), .uart_rx_data(uart_rx_data), .uart_rx_clear(uart_rx_clear),
      .uart_tx_busy(uart_tx_busy), .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
      .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_req(input logic [1:0] use_c, input logic we, input logic [31:0] addr,
                          input logic [19:0] raddr, input logic [31:0] wdata, input logic [3:0] be);
      mem_use   = use_c;
      mem_we    = we;
      mem_addr  = addr;
      ram_addr  = raddr;
      mem_wdata = wdata;
      mem_be    = be;
      mem_req   = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
      mem_use = '0; ram_addr = '0; base_ram_data_i = '0; ext_ram_data_i = '0;
      uart_rx_ready = 1'b0; uart_rx_data = '0; uart_tx_busy = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n} !== 6'b111111) begin
         bad++;
         $display("FAIL reset_strobes got=%b%b%b_%b%b%b expected=111_111", base_ram_ce_n, base_ram_oe_n,
                  base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n);
      end
      total++;
      if (base_ram_be_n !== 4'hF || ext_ram_be_n !== 4'hF || base_ram_data_oe !== 1'b0 || ext_ram_data_oe !== 1'b0) begin
         bad++;
         $display("FAIL reset_be_oe be_n=%h/%h data_oe=%b/%b expected F/F 0/0", base_ram_be_n, ext_ram_be_n,
                  base_ram_data_oe, ext_ram_data_oe);
      end
      total++;
      if (base_ram_addr !== 20'h0 || ext_ram_addr !== 20'h0 || base_ram_data_o !== 32'h0 || ext_ram_data_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_addr_data got %h %h %h %h expected all zero", base_ram_addr, ext_ram_addr,
                  base_ram_data_o, ext_ram_data_o);
      end
      total++;
      if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || uart_rx_clear !== 1'b0 || uart_tx_start !== 1'b0 ||
          uart_tx_data !== 8'h0 || vga_we !== 1'b0 || vga_addr !== 19'h0 || vga_wdata !== 8'h0) begin
         bad++;
         $display("FAIL reset_outputs ready=%b rdata=%h rxc=%b txs=%b txd=%h vga=%b/%h/%h expected all zero",
                  mem_ready, mem_rdata, uart_rx_clear, uart_tx_start, uart_tx_data, vga_we, vga_addr, vga_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_base_read();
      int n = 0;
      bit got = 0;
      bit ext_touch = 0;
      base_ram_data_i = 32'hDEADBEEF;
      set_req(USE_BASE, 1'b0, 32'h0000_0040, 20'h00010, 32'h0, 4'hF);
      while (!got && n < 10) begin
         @(posedge clk); @(negedge clk); n++;
         if (ext_ram_ce_n !== 1'b1) ext_touch = 1;
         if (n == 1) begin
            total++;
            if (base_ram_ce_n !== 1'b0 || base_ram_oe_n !== 1'b0 || base_ram_we_n !== 1'b1 ||
                base_ram_be_n !== 4'h0 || base_ram_addr !== 20'h00010) begin
               bad++;
               $display("FAIL base_rd_strobe ce_n=%b oe_n=%b we_n=%b be_n=%h addr=%h expected 0 0 1 0 00010",
                        base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n, base_ram_addr);
            end
         end
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || n != 3) begin
         bad++;
         $display("FAIL base_rd_latency got=%0d expected=3 (ready seen=%0d)", n, got);
      end
      total++;
      if (mem_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL base_rd_data got=%h expected=deadbeef", mem_rdata);
      end
      total++;
      if (base_ram_ce_n !== 1'b1 || base_ram_oe_n !== 1'b1 || ext_touch) begin
         bad++;
         $display("FAIL base_rd_release ce_n=%b oe_n=%b ext_touched=%0d expected 1 1 0",
                  base_ram_ce_n, base_ram_oe_n, ext_touch);
      end
      @(posedge clk); @(negedge clk);
      total++;
      if (mem_ready !== 1'b0) begin
         bad++;
         $display("FAIL base_rd_ready_width got=%b expected=0", mem_ready);
      end
   endtask

   task automatic test_ext_write();
      int n = 0;
      int we_low = 0;
      bit got = 0;
      bit base_touch = 0;
      set_req(USE_EXT, 1'b1, 32'h0000_0100, 20'h12345, 32'h0000AB00, 4'b0010);
      while (!got && n < 10) begin
         @(posedge clk); @(negedge clk); n++;
         if (base_ram_ce_n !== 1'b1 || base_ram_we_n !== 1'b1 || base_ram_data_oe !== 1'b0) base_touch = 1;
         if (ext_ram_we_n === 1'b0) we_low++;
         if (n == 1) begin
            total++;
            if (ext_ram_ce_n !== 1'b0 || ext_ram_we_n !== 1'b0 || ext_ram_oe_n !== 1'b1 || ext_ram_data_oe !== 1'b1 ||
                ext_ram_be_n !== 4'b1101 || ext_ram_data_o !== 32'h0000AB00 || ext_ram_addr !== 20'h12345) begin
               bad++;
               $display("FAIL ext_wr_strobe ce_n=%b we_n=%b oe_n=%b oe=%b be_n=%b data=%h addr=%h expected 0 0 1 1 1101 0000ab00 12345",
                        ext_ram_ce_n, ext_ram_we_n, ext_ram_oe_n, ext_ram_data_oe, ext_ram_be_n, ext_ram_data_o, ext_ram_addr);
            end
         end
         if (n == 3) begin
            total++;
            if (ext_ram_we_n !== 1'b1 || ext_ram_ce_n !== 1'b0 || ext_ram_data_oe !== 1'b1) begin
               bad++;
               $display("FAIL ext_wr_hold we_n=%b ce_n=%b data_oe=%b expected 1 0 1", ext_ram_we_n, ext_ram_ce_n, ext_ram_data_oe);
            end
         end
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || n != 4) begin
         bad++;
         $display("FAIL ext_wr_latency got=%0d expected=4 (ready seen=%0d)", n, got);
      end
      total++;
      if (we_low != 2) begin
         bad++;
         $display("FAIL ext_wr_we_width got=%0d expected=2", we_low);
      end
      total++;
      if (base_touch || ext_ram_ce_n !== 1'b1 || ext_ram_data_oe !== 1'b0 || ext_ram_be_n !== 4'hF) begin
         bad++;
         $display("FAIL ext_wr_release base_touched=%0d ce_n=%b data_oe=%b be_n=%h expected 0 1 0 f",
                  base_touch, ext_ram_ce_n, ext_ram_data_oe, ext_ram_be_n);
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_uart_read();
      int n = 0;
      int clr = 0;
      bit got = 0;
      uart_rx_ready = 1'b1; uart_tx_busy = 1'b0; uart_rx_data = 8'h41;
      set_req(USE_UART, 1'b0, 32'h1000_0005, 20'h0, 32'h0, 4'hF);
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (uart_rx_clear === 1'b1) clr++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || mem_rdata !== 32'h00002100 || clr != 0) begin
         bad++;
         $display("FAIL uart_lsr rdata=%h ready=%0d rx_clear_pulses=%0d expected 00002100 1 0", mem_rdata, got, clr);
      end
      @(posedge clk); @(negedge clk);
      n = 0; got = 0; clr = 0;
      set_req(USE_UART, 1'b0, 32'h1000_0000, 20'h0, 32'h0, 4'hF);
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (uart_rx_clear === 1'b1) clr++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (uart_rx_clear === 1'b1) clr++;
      end
      total++;
      if (!got || mem_rdata !== 32'h00000041) begin
         bad++;
         $display("FAIL uart_data_rd rdata=%h ready=%0d expected 00000041 1", mem_rdata, got);
      end
      total++;
      if (clr != 1) begin
         bad++;
         $display("FAIL uart_rx_clear_pulse got=%0d expected=1", clr);
      end
   endtask

   task automatic test_uart_tx();
      int n = 0;
      int starts = 0;
      int early = 0;
      bit got = 0;
      uart_tx_busy = 1'b1;
      set_req(USE_UART, 1'b1, 32'h1000_0000, 20'h0, 32'h0000_0055, 4'h1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         if (uart_tx_start !== 1'b0 || mem_ready !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL uart_tx_busy_hold early_cycles=%0d expected=0", early);
      end
      uart_tx_busy = 1'b0;
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (uart_tx_start === 1'b1) starts++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || n != 1 || uart_tx_data !== 8'h55) begin
         bad++;
         $display("FAIL uart_tx_release cycles=%0d ready=%0d tx_data=%h expected 1 1 55", n, got, uart_tx_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (uart_tx_start === 1'b1) starts++;
      end
      total++;
      if (starts != 1) begin
         bad++;
         $display("FAIL uart_tx_start_pulse got=%0d expected=1", starts);
      end
      n = 0; got = 0; starts = 0;
      set_req(USE_UART, 1'b1, 32'h1000_0003, 20'h0, 32'h0000_00AA, 4'h1);
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (uart_tx_start === 1'b1) starts++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      @(posedge clk); @(negedge clk);
      total++;
      if (!got || starts != 0 || uart_tx_data !== 8'h55) begin
         bad++;
         $display("FAIL uart_other_ofs_wr ready=%0d starts=%0d tx_data=%h expected 1 0 55", got, starts, uart_tx_data);
      end
   endtask

   task automatic test_vga();
      int n = 0;
      int strobes = 0;
      bit got = 0;
      set_req(USE_VGA, 1'b1, 32'h2000_0123, 20'h0, 32'h0000_001C, 4'h1);
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (vga_we === 1'b1) begin
            strobes++;
            total++;
            if (vga_addr !== 19'h00123 || vga_wdata !== 8'h1C) begin
               bad++;
               $display("FAIL vga_wr_payload addr=%h data=%h expected 00123 1c", vga_addr, vga_wdata);
            end
         end
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (vga_we === 1'b1) strobes++;
      end
      total++;
      if (!got || strobes != 1) begin
         bad++;
         $display("FAIL vga_wr_strobe ready=%0d strobes=%0d expected 1 1", got, strobes);
      end
      n = 0; got = 0;
      set_req(USE_VGA, 1'b0, 32'h2000_0004, 20'h0, 32'h0, 4'hF);
      while (!got && n < 6) begin
         @(posedge clk); @(negedge clk); n++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || mem_rdata !== 32'h0 || vga_we !== 1'b0) begin
         bad++;
         $display("FAIL vga_rd ready=%0d rdata=%h vga_we=%b expected 1 00000000 0", got, mem_rdata, vga_we);
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      int n = 0;
      bit got = 0;
      set_req(USE_BASE, 1'b1, 32'h0, 20'h00777, 32'hCAFEF00D, 4'hF);
      @(posedge clk); @(negedge clk);
      total++;
      if (base_ram_we_n !== 1'b0 || base_ram_data_oe !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre we_n=%b data_oe=%b expected 0 1", base_ram_we_n, base_ram_data_oe);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (base_ram_we_n !== 1'b1 || base_ram_ce_n !== 1'b1 || base_ram_data_oe !== 1'b0 || base_ram_be_n !== 4'hF) begin
         bad++;
         $display("FAIL rst_mid_async we_n=%b ce_n=%b data_oe=%b be_n=%h expected 1 1 0 f",
                  base_ram_we_n, base_ram_ce_n, base_ram_data_oe, base_ram_be_n);
      end
      mem_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      total++;
      if (mem_ready !== 1'b0 || base_ram_ce_n !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_idle ready=%b ce_n=%b expected 0 1", mem_ready, base_ram_ce_n);
      end
      ext_ram_data_i = 32'h1234_5678;
      set_req(USE_EXT, 1'b0, 32'h0, 20'h00ABC, 32'h0, 4'hF);
      while (!got && n < 10) begin
         @(posedge clk); @(negedge clk); n++;
         if (mem_ready === 1'b1) got = 1;
      end
      mem_req = 1'b0;
      total++;
      if (!got || n != 3 || mem_rdata !== 32'h12345678) begin
         bad++;
         $display("FAIL post_rst_ext_rd cycles=%0d ready=%0d rdata=%h expected 3 1 12345678", n, got, mem_rdata);
      end
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_base_read();
      test_ext_write();
      test_uart_read();
      test_uart_tx();
      test_vga();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
